// File: rtl/fetch_group_seq_if.sv
// Fetch sequencer bus bundle: redirect input, imem request/response, decode group output.
interface fetch_group_seq_if;
  localparam int unsigned LANES  = 8;
  localparam int unsigned GRP_W  = LANES * 32;

  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ready;
  logic [GRP_W-1:0]   imem_data;
  logic               grp_valid;
  logic               grp_ready;
  logic [GRP_W-1:0]   grp_pc;
  logic [GRP_W-1:0]   grp_instr;
  logic [LANES-1:0]   grp_mask;
  logic               grp_br_taken;

  // Sequencer side
  modport master (
    input  redirect_valid, redirect_pc, imem_ready, imem_data, grp_ready,
    output imem_req, imem_addr, grp_valid, grp_pc, grp_instr, grp_mask, grp_br_taken
  );

  // Memory / decode / back-end side
  modport slave (
    output redirect_valid, redirect_pc, imem_ready, imem_data, grp_ready,
    input  imem_req, imem_addr, grp_valid, grp_pc, grp_instr, grp_mask, grp_br_taken
  );
endinterface

// File: rtl/fetch_group_seq.sv
// 8-wide fetch group sequencer: requests groups, trims at first unconditional
// branch (beq $0,$0), computes next base PC, hands groups to decode.
module fetch_group_seq #(
  parameter int unsigned LANES    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  fetch_group_seq_if.master bus
);
  localparam int unsigned GRP_W      = LANES * 32;
  localparam logic [15:0] UNCOND_BR  = 16'h1000;
  localparam logic [31:0] GROUP_STEP = 32'(LANES * 4);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state;
  logic [31:0]        base;
  logic [31:0]        next_base;
  logic               grp_valid;
  logic [GRP_W-1:0]   grp_pc;
  logic [GRP_W-1:0]   grp_instr;
  logic [LANES-1:0]   grp_mask;
  logic               grp_br_taken;

  logic [GRP_W-1:0]   lane_pc;
  logic               br_found;
  logic [2:0]         br_lane;
  logic [LANES-1:0]   scan_mask;
  logic [31:0]        br_instr;
  logic [31:0]        br_offset;
  logic [31:0]        scan_next;

  // Lane PCs relative to the current base, modulo 2^32
  always_comb begin
    lane_pc = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_pc[32*k +: 32] = base + 32'(4 * k);
    end
  end

  // Find lowest unconditional branch lane in the incoming group and derive mask / next base
  always_comb begin
    br_found  = 1'b0;
    br_lane   = 3'd0;
    scan_mask = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (!br_found && (bus.imem_data[32*k+16 +: 16] == UNCOND_BR)) begin
        br_found = 1'b1;
        br_lane  = 3'(k);
      end
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      scan_mask[k] = !br_found || (3'(k) <= br_lane);
    end
    br_instr  = bus.imem_data[32*br_lane +: 32];
    br_offset = {{14{br_instr[15]}}, br_instr[15:0], 2'b00};
    scan_next = br_found ? (base + {27'd0, br_lane, 2'b00} + 32'd4 + br_offset)
                         : (base + GROUP_STEP);
  end

  // Sequencer state, base PC and registered group outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base         <= RESET_PC;
      next_base    <= RESET_PC;
      grp_valid    <= 1'b0;
      grp_pc       <= '0;
      grp_instr    <= '0;
      grp_mask     <= '0;
      grp_br_taken <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Redirect squashes any in-flight handshake on this edge
      state     <= REQ;
      base      <= bus.redirect_pc & 32'hFFFF_FFFC;
      grp_valid <= 1'b0;
      grp_mask  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (bus.imem_ready) begin
            state        <= HOLD;
            grp_valid    <= 1'b1;
            grp_pc       <= lane_pc;
            grp_instr    <= bus.imem_data;
            grp_mask     <= scan_mask;
            grp_br_taken <= br_found;
            next_base    <= scan_next;
          end
        end
        HOLD: begin
          if (bus.grp_ready) begin
            state     <= REQ;
            base      <= next_base;
            grp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers or from the state decode
  assign bus.imem_req     = (state == REQ);
  assign bus.imem_addr    = base;
  assign bus.grp_valid    = grp_valid;
  assign bus.grp_pc       = grp_pc;
  assign bus.grp_instr    = grp_instr;
  assign bus.grp_mask     = grp_mask;
  assign bus.grp_br_taken = grp_br_taken;

endmodule

// File: tb/tb_fetch_group_seq.sv
// Directed self-checking bench for fetch_group_seq.
module tb_fetch_group_seq;
  logic clk = 1'b0;
  logic rst;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  logic [255:0] data;

  fetch_group_seq_if bus();

  fetch_group_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge, then sample away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // Fill all lanes with a non-branch opcode pattern
  task automatic fill_plain();
    for (int k = 0; k < 8; k++) data[32*k +: 32] = 32'h0010_0093 + 32'(k);
  endtask

  initial begin
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ready     = 1'b0;
    bus.imem_data      = '0;
    bus.grp_ready      = 1'b0;
    data               = '0;

    // Reset held three cycles
    tick(); tick(); tick();
    check("rst_req",   256'(bus.imem_req),  256'(0));
    check("rst_valid", 256'(bus.grp_valid), 256'(0));
    check("rst_mask",  256'(bus.grp_mask),  256'(0));
    check("rst_addr",  256'(bus.imem_addr), 256'(0));
    rst = 1'b0;
    tick();
    check("rel_req",   256'(bus.imem_req),  256'(1));
    check("rel_addr",  256'(bus.imem_addr), 256'(0));
    check("rel_pc",    bus.grp_pc,          256'(0));
    check("rel_instr", bus.grp_instr,       256'(0));
    check("rel_br",    256'(bus.grp_br_taken), 256'(0));

    // Straight-line group at 0x100
    redirect(32'h100);
    check("sl_addr", 256'(bus.imem_addr), 256'(32'h100));
    fill_plain();
    bus.imem_data  = data;
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    check("sl_valid", 256'(bus.grp_valid), 256'(1));
    check("sl_req",   256'(bus.imem_req),  256'(0));
    check("sl_mask",  256'(bus.grp_mask),  256'(8'hFF));
    check("sl_br",    256'(bus.grp_br_taken), 256'(0));
    check("sl_pc7",   256'(bus.grp_pc[255:224]), 256'(32'h11C));
    check("sl_pc0",   256'(bus.grp_pc[31:0]),    256'(32'h100));
    check("sl_ins2",  256'(bus.grp_instr[95:64]), 256'(32'h0010_0095));
    bus.grp_ready = 1'b1;
    tick();
    bus.grp_ready = 1'b0;
    check("sl_next_req",  256'(bus.imem_req),  256'(1));
    check("sl_next_addr", 256'(bus.imem_addr), 256'(32'h120));
    check("sl_next_val",  256'(bus.grp_valid), 256'(0));

    // Forward branch at lane 3; lane 5 branch ignored
    redirect(32'h200);
    data = '0;
    data[127:96]  = 32'h1000_0010;
    data[191:160] = 32'h1000_0002;
    bus.imem_data  = data;
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    check("fw_mask", 256'(bus.grp_mask),     256'(8'h0F));
    check("fw_br",   256'(bus.grp_br_taken), 256'(1));
    check("fw_pc5",  256'(bus.grp_pc[191:160]),    256'(32'h214));
    check("fw_ins5", 256'(bus.grp_instr[191:160]), 256'(32'h1000_0002));
    bus.grp_ready = 1'b1;
    tick();
    bus.grp_ready = 1'b0;
    check("fw_next", 256'(bus.imem_addr), 256'(32'h250));

    // Backward branch at lane 0
    redirect(32'h400);
    data = '0;
    data[31:0] = 32'h1000_FFFE;
    bus.imem_data  = data;
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    check("bw_mask", 256'(bus.grp_mask), 256'(8'h01));
    bus.grp_ready = 1'b1;
    tick();
    bus.grp_ready = 1'b0;
    check("bw_next", 256'(bus.imem_addr), 256'(32'h3FC));
    check("bw_req",  256'(bus.imem_req),  256'(1));

    // Backpressure: capture plain group at 0x3FC, hold five cycles
    fill_plain();
    bus.imem_data  = data;
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 256'(bus.grp_valid), 256'(1));
      check("bp_mask",  256'(bus.grp_mask),  256'(8'hFF));
      check("bp_pc0",   256'(bus.grp_pc[31:0]), 256'(32'h3FC));
      check("bp_req",   256'(bus.imem_req),  256'(0));
      tick();
    end
    bus.grp_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1237;
    tick();
    bus.grp_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    check("rd_valid", 256'(bus.grp_valid), 256'(0));
    check("rd_mask",  256'(bus.grp_mask),  256'(0));
    check("rd_addr",  256'(bus.imem_addr), 256'(32'h1234));
    check("rd_req",   256'(bus.imem_req),  256'(1));

    // Redirect on the same edge as a memory handshake discards the handshake
    bus.imem_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF0;
    tick();
    bus.imem_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    check("rdh_valid", 256'(bus.grp_valid), 256'(0));
    check("rdh_addr",  256'(bus.imem_addr), 256'(32'hFFFF_FFF0));

    // Stalled memory keeps request and address stable
    for (int c = 0; c < 4; c++) begin
      tick();
      check("st_req",  256'(bus.imem_req),  256'(1));
      check("st_addr", 256'(bus.imem_addr), 256'(32'hFFFF_FFF0));
    end

    // Wrap past 0xFFFF_FFFC
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    check("wr_pc0", 256'(bus.grp_pc[31:0]),    256'(32'hFFFF_FFF0));
    check("wr_pc4", 256'(bus.grp_pc[159:128]), 256'(32'h0000_0000));
    check("wr_mask", 256'(bus.grp_mask), 256'(8'hFF));
    bus.grp_ready = 1'b1;
    tick();
    bus.grp_ready = 1'b0;
    check("wr_next", 256'(bus.imem_addr), 256'(32'h0000_0010));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
